// File: rtl/tcdm_bank_arbiter_if.sv
// Bus bundle between NB_MASTERS requesters, the bank arbiter and the single memory bank.
// "slave" is the arbiter's view; "master" is the requesters-plus-bank environment.
interface tcdm_bank_arbiter_if #(
    parameter int unsigned NB_MASTERS = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic [NB_MASTERS-1:0]                 req;
    logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0] add;
    logic [NB_MASTERS-1:0]                 wen;
    logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] data;
    logic [NB_MASTERS-1:0][BE_WIDTH-1:0]   be;
    logic [NB_MASTERS-1:0]                 gnt;
    logic [NB_MASTERS-1:0]                 r_valid;
    logic [DATA_WIDTH-1:0]                 r_data;

    logic                  bank_req;
    logic [ADDR_WIDTH-1:0] bank_add;
    logic                  bank_wen;
    logic [DATA_WIDTH-1:0] bank_data;
    logic [BE_WIDTH-1:0]   bank_be;
    logic                  bank_gnt;
    logic [DATA_WIDTH-1:0] bank_r_data;

    modport slave (
        input  req, add, wen, data, be, bank_gnt, bank_r_data,
        output gnt, r_valid, r_data, bank_req, bank_add, bank_wen, bank_data, bank_be
    );

    modport master (
        output req, add, wen, data, be, bank_gnt, bank_r_data,
        input  gnt, r_valid, r_data, bank_req, bank_add, bank_wen, bank_data, bank_be
    );
endinterface

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM bank among NB_MASTERS ports, with a fixed
// one-cycle response path and a saturating conflict counter.
module tcdm_bank_arbiter #(
    parameter int unsigned NB_MASTERS = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    tcdm_bank_arbiter_if.slave   bus,
    input  logic                 cnt_clr_i,
    output logic [CNT_WIDTH-1:0] conflict_cnt_o
);
    localparam int unsigned IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    idx_t                  rr_ptr_q, rr_ptr_d;
    logic                  rvalid_q, rvalid_d;
    idx_t                  owner_q, owner_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    idx_t cand;
    idx_t win_idx;
    logic win_found;
    logic granted;
    logic multi_req;
    logic conflict;

    // First requester at or after rr_ptr_q, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < int'(NB_MASTERS); i++) begin
            cand = idx_t'((int'(rr_ptr_q) + i) % int'(NB_MASTERS));
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        bus.bank_req  = |bus.req;
        bus.bank_add  = '0;
        bus.bank_wen  = 1'b1;
        bus.bank_data = '0;
        bus.bank_be   = '0;
        if (win_found) begin
            bus.bank_add  = bus.add[win_idx];
            bus.bank_wen  = bus.wen[win_idx];
            bus.bank_data = bus.data[win_idx];
            bus.bank_be   = bus.be[win_idx];
        end
    end

    assign granted = win_found && bus.bank_gnt;

    // Grant is masked during reset so no master sees an acceptance that is then dropped.
    always_comb begin
        bus.gnt = '0;
        if (granted && rst_ni) begin
            bus.gnt[win_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        rvalid_d = granted;
        if (granted) begin
            rr_ptr_d = (win_idx == idx_t'(NB_MASTERS - 1)) ? '0 : win_idx + 1'b1;
            owner_d  = win_idx;
        end
    end

    always_comb begin
        bus.r_valid = '0;
        if (rvalid_q) begin
            bus.r_valid[owner_q] = 1'b1;
        end
        bus.r_data = rvalid_q ? bus.bank_r_data : '0;
    end

    // Two or more bits set <=> clearing the lowest set bit leaves something.
    assign multi_req = |(bus.req & (bus.req - NB_MASTERS'(1)));
    assign conflict  = multi_req || (bus.bank_req && !bus.bank_gnt);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (conflict && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign conflict_cnt_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            rvalid_q <= 1'b0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rvalid_q <= rvalid_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Randomized and directed bench for tcdm_bank_arbiter against a behavioural model of the
// round-robin arbiter, the one-cycle response path, the conflict counter and a memory bank.
module tb_tcdm_bank_arbiter;
    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int CW  = 4;
    localparam int BW  = DW / 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cnt_clr = 1'b0;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    tcdm_bank_arbiter_if #(.NB_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    tcdm_bank_arbiter #(
        .NB_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus            (bus),
        .cnt_clr_i      (cnt_clr),
        .conflict_cnt_o (cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    int m_rr, m_owner, m_cnt;
    bit m_rv;
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] next_rdata;

    logic [N-1:0]  obs_gnt, obs_rv;
    logic [DW-1:0] obs_rdata;
    logic [CW-1:0] obs_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    // One clock: check all outputs mid-cycle, then advance the model at the rising edge.
    task automatic cycle();
        int w;
        bit granted, conflict;
        logic [N-1:0]  e_gnt, e_rv;
        logic [AW-1:0] e_add;
        logic [DW-1:0] e_data, e_rdata, mask, old;
        logic [BW-1:0] e_be;
        logic          e_wen;
        if (!rst_n) begin
            m_rr = 0; m_rv = 0; m_owner = 0; m_cnt = 0;
        end
        #1;
        w = pick(bus.req, m_rr);
        granted = (w >= 0) && bus.bank_gnt;
        e_add = '0; e_data = '0; e_be = '0; e_wen = 1'b1; e_gnt = '0; e_rv = '0;
        if (w >= 0) begin
            e_add = bus.add[w]; e_data = bus.data[w]; e_be = bus.be[w]; e_wen = bus.wen[w];
            if (granted && rst_n) e_gnt[w] = 1'b1;
        end
        if (m_rv) e_rv[m_owner] = 1'b1;
        e_rdata = m_rv ? bus.bank_r_data : '0;
        obs_gnt = bus.gnt; obs_rv = bus.r_valid; obs_rdata = bus.r_data; obs_cnt = cnt;
        chk("bank_req",  64'(bus.bank_req),  64'(w >= 0));
        chk("bank_add",  64'(bus.bank_add),  64'(e_add));
        chk("bank_wen",  64'(bus.bank_wen),  64'(e_wen));
        chk("bank_data", 64'(bus.bank_data), 64'(e_data));
        chk("bank_be",   64'(bus.bank_be),   64'(e_be));
        chk("gnt",       64'(bus.gnt),       64'(e_gnt));
        chk("r_valid",   64'(bus.r_valid),   64'(e_rv));
        chk("r_data",    64'(bus.r_data),    64'(e_rdata));
        chk("cnt",       64'(cnt),           64'(m_cnt));
        conflict = ($countones(bus.req) >= 2) || ((w >= 0) && !bus.bank_gnt);
        @(posedge clk);
        next_rdata = $urandom;
        if (rst_n) begin
            if (granted) begin
                m_rr = (w + 1) % N; m_owner = w; m_rv = 1;
                if (bus.wen[w]) begin
                    next_rdata = rd(bus.add[w]);
                end else begin
                    for (int b = 0; b < BW; b++) mask[8*b +: 8] = bus.be[w][b] ? 8'hFF : 8'h00;
                    old = rd(bus.add[w]);
                    mem[bus.add[w]] = (old & ~mask) | (bus.data[w] & mask);
                end
            end else begin
                m_rv = 0;
            end
            if (cnt_clr) m_cnt = 0;
            else if (conflict && m_cnt < CNT_MAX) m_cnt++;
        end
        @(negedge clk);
        bus.bank_r_data = next_rdata;
    endtask

    task automatic idle();
        bus.req = '0; bus.add = '0; bus.wen = '1; bus.data = '0; bus.be = '0;
        bus.bank_gnt = 1'b1; cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic drive(input int m, input bit is_read, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] b);
        bus.req[m] = 1'b1; bus.wen[m] = is_read; bus.add[m] = a; bus.data[m] = d; bus.be[m] = b;
    endtask

    logic [N-1:0] seq [5];

    initial begin
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        bus.bank_r_data = $urandom;
        idle();
        @(negedge clk);
        do_reset();
        chk("rst_gnt", 64'(obs_gnt), 64'd0);
        chk("rst_rv",  64'(obs_rv),  64'd0);
        chk("rst_cnt", 64'(obs_cnt), 64'd0);

        // All four requesting continuously from a fresh reset
        bus.req = 4'b1111; bus.wen = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_seq", 64'(obs_gnt), 64'(seq[i]));
            if (i > 0) chk("rr_rv", 64'(obs_rv), 64'(seq[i-1]));
            chk("rr_cnt", 64'(obs_cnt), 64'(i));
        end

        // Stalled bank: pointer must hold, master 0 wins once the bank accepts
        do_reset();
        bus.req = 4'b0011; bus.wen = 4'b0011; bus.bank_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_gnt", 64'(obs_gnt), 64'd0);
        end
        bus.bank_gnt = 1'b1;
        cycle();
        chk("stall_win", 64'(obs_gnt), 64'b0001);
        idle();
        cycle();
        chk("stall_cnt", 64'(obs_cnt), 64'd4);
        chk("stall_rv",  64'(obs_rv),  64'b0001);

        // Single master read
        drive(2, 1'b1, 32'h10, '0, '0);
        cycle();
        chk("single_gnt", 64'(obs_gnt), 64'b0100);
        idle();
        cycle();
        chk("single_rv", 64'(obs_rv), 64'b0100);

        // Write from master 1 then read back from master 3
        drive(1, 1'b0, 32'h100, 32'hA5A5_5A5A, 4'b0101);
        cycle();
        idle();
        drive(3, 1'b1, 32'h100, '0, '0);
        cycle();
        chk("wr_rv", 64'(obs_rv), 64'b0010);
        idle();
        cycle();
        chk("rd_rv",   64'(obs_rv),    64'b1000);
        chk("rd_data", 64'(obs_rdata), 64'h00A5_005A);

        // Counter saturation and clear
        bus.req = 4'b1111;
        for (int i = 0; i < 20; i++) cycle();
        cnt_clr = 1'b1;
        cycle();
        chk("sat_cnt", 64'(obs_cnt), 64'(CNT_MAX));
        cnt_clr = 1'b0;
        cycle();
        chk("clr_cnt", 64'(obs_cnt), 64'd0);

        // Reset with a response pending
        do_reset();
        drive(2, 1'b1, 32'h20, '0, '0);
        cycle();
        chk("pre_rst_gnt", 64'(obs_gnt), 64'b0100);
        idle();
        rst_n = 1'b0;
        cycle();
        chk("in_rst_rv", 64'(obs_rv), 64'd0);
        rst_n = 1'b1;
        bus.req = 4'b0011;
        cycle();
        chk("post_rst_rv",  64'(obs_rv),  64'd0);
        chk("post_rst_gnt", 64'(obs_gnt), 64'b0001);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < N; m++) begin
                bus.req[m]  = ($urandom_range(0, 99) < 45);
                bus.wen[m]  = $urandom_range(0, 1);
                bus.add[m]  = 32'($urandom_range(0, 7) * 4);
                bus.data[m] = $urandom;
                bus.be[m]   = 4'($urandom_range(0, 15));
            end
            bus.bank_gnt = ($urandom_range(0, 99) < 75);
            cnt_clr = ($urandom_range(0, 99) < 3);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
